// File: rtl/cnt_sweep_pkg.sv
// cnt_sweep_pkg: shared types and constants for the sweep sequencer.
//   sweep_state_t : FSM state encoding (IDLE, RUN, DONE)
//   MODE_*        : command mode encoding (single / ping-pong)
//   DIR_*         : direction encoding, identical to the counter's U_D pin
//   cnt_width()   : counter width for a given upper bound (never below 1)
package cnt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

  localparam logic MODE_SINGLE   = 1'b0;
  localparam logic MODE_PINGPONG = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cnt_sweep_dir.sv
// cnt_sweep_dir: ping-pong direction logic for the sweep sequencer.
// Holds the sweep direction register and forces the direction away from a
// bound when the counter sits on it, so a ping-pong sweep reflects instead
// of wrapping.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : command accepted this cycle; load_dir becomes the direction
//   load_dir   : commanded direction (1 = down)
//   step       : counter steps at the coming edge
//   active     : ping-pong sweep in RUN; enables the bound override
//   cnt_in     : current counter value
//   cnt_ud     : direction presented to the counter
module cnt_sweep_dir
  import cnt_sweep_pkg::*;
#(
  parameter int MAX = 15,
  parameter int MIN = 0,
  parameter int CW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          load_dir,
  input  logic          step,
  input  logic          active,
  input  logic [CW-1:0] cnt_in,
  output logic          cnt_ud
);

  logic dir_q;
  logic bound_ud;

  // A degenerate range (MIN == MAX) has no direction to reflect into, so the
  // stored direction is kept as-is.
  always_comb begin
    bound_ud = dir_q;
    if (MIN != MAX) begin
      if (cnt_in == CW'(MAX)) begin
        bound_ud = DIR_DOWN;
      end else if (cnt_in == CW'(MIN)) begin
        bound_ud = DIR_UP;
      end
    end
  end

  // Outside an active ping-pong sweep the counter simply sees dir_q.
  assign cnt_ud = active ? bound_ud : dir_q;

  // The direction actually used by a step is remembered, so after a bounce
  // the sweep keeps travelling the reflected way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q <= DIR_UP;
    end else if (load) begin
      dir_q <= load_dir;
    end else if (step && active) begin
      dir_q <= bound_ud;
    end
  end

endmodule

// File: rtl/cnt_sweep_ctrl.sv
// cnt_sweep_ctrl: sequencer for a bounded up/down wrap counter.
// Takes sweep commands (direction, step count, mode) and drives the
// counter's enable / U_D so it advances exactly the commanded number of
// steps, then pulses done for one cycle.
// Optional feature macro: CNT_SWEEP_PINGPONG_EN. When defined, cmd_mode is
// honoured and ping-pong sweeps reflect at MIN/MAX. When undefined, every
// sweep is single mode (the counter wraps) and no bound compare exists.
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE and does not
// depend on cmd_valid; the command fields are sampled only at that edge.
// Ports:
//   clk, sys_rst           : clock, asynchronous active-high reset
//   cmd_valid / cmd_ready  : command handshake
//   cmd_dir                : 1 = down, 0 = up (same encoding as U_D)
//   cmd_steps              : number of counter steps
//   cmd_mode               : 0 = single, 1 = ping-pong
//   hold                   : pauses stepping while high
//   abort                  : cancels the active sweep (ignored in IDLE)
//   cnt_in                 : counter value fed back from the counter
//   cnt_en, cnt_ud         : counter enable and direction
//   busy                   : high in RUN or DONE
//   done                   : one-cycle completion pulse
//   steps_left             : remaining steps of the current sweep
//   state                  : current FSM state (debug visibility)
module cnt_sweep_ctrl
  import cnt_sweep_pkg::*;
#(
  parameter int  MAX    = 15,
  parameter int  MIN    = 0,
  parameter int  STEP_W = 8,
  localparam int CW     = cnt_width(MAX)
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_mode,
  input  logic              hold,
  input  logic              abort,
  input  logic [CW-1:0]     cnt_in,
  output logic              cnt_en,
  output logic              cnt_ud,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] steps_left,
  output sweep_state_t      state
);

  logic accept;

  // All status outputs decode the state register directly; cnt_en and done
  // also see abort so that an abort cycle never steps and never completes.
  // Async reset clears state, so cnt_en drops the moment sys_rst rises.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign cnt_en    = (state == RUN) && !hold && !abort;
  assign done      = (state == DONE) && !abort;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      steps_left <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            steps_left <= cmd_steps;
            // A zero-step command goes straight to DONE without stepping.
            state      <= (cmd_steps == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state      <= IDLE;
            steps_left <= '0;
          end else if (cnt_en) begin
            steps_left <= steps_left - STEP_W'(1);
            if (steps_left == STEP_W'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          steps_left <= '0;
        end
        default: begin
          state      <= IDLE;
          steps_left <= '0;
        end
      endcase
    end
  end

`ifdef CNT_SWEEP_PINGPONG_EN
  logic mode_q;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode_q <= MODE_SINGLE;
    end else if (accept) begin
      mode_q <= cmd_mode;
    end
  end

  // The bound override is only live while a ping-pong sweep is running, so
  // in IDLE/DONE the counter always sees the settled stored direction.
  cnt_sweep_dir #(
    .MAX (MAX),
    .MIN (MIN),
    .CW  (CW)
  ) u_dir (
    .clk      (clk),
    .rst      (sys_rst),
    .load     (accept),
    .load_dir (cmd_dir),
    .step     (cnt_en),
    .active   ((state == RUN) && (mode_q == MODE_PINGPONG)),
    .cnt_in   (cnt_in),
    .cnt_ud   (cnt_ud)
  );
`else
  logic dir_q;
  logic unused_cfg;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      dir_q <= DIR_UP;
    end else if (accept) begin
      dir_q <= cmd_dir;
    end
  end

  assign cnt_ud = dir_q;

  // Single-mode-only build: mode, counter feedback and the lower bound have
  // no effect on the outputs.
  assign unused_cfg = cmd_mode ^ (^cnt_in) ^ (MIN > MAX);
`endif

endmodule

// File: tb/tb_cnt_sweep_ctrl.sv
// tb_cnt_sweep_ctrl: self-checking bench for cnt_sweep_ctrl.
// Contains a behavioural model of the attached wrap counter (samples U_D on
// the falling edge, steps on the rising edge when enabled) and a sweep
// reference that precomputes the expected counter trajectory for each
// command. Directed scenarios are followed by randomized commands with
// random hold windows, aborts and start values.
module tb_cnt_sweep_ctrl;
  import cnt_sweep_pkg::*;

  localparam int MAX    = 15;
  localparam int MIN    = 0;
  localparam int STEP_W = 8;
  localparam int CW     = cnt_width(MAX);
  localparam int RANGE  = MAX - MIN + 1;
`ifdef CNT_SWEEP_PINGPONG_EN
  localparam bit PP_BUILD = 1'b1;
`else
  localparam bit PP_BUILD = 1'b0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic              clk;
  logic              sys_rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_mode;
  logic              hold;
  logic              abort;
  logic [CW-1:0]     cnt;
  logic              cnt_en;
  logic              cnt_ud;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] steps_left;
  sweep_state_t      state_dbg;

  logic              load;
  logic [CW-1:0]     load_val;
  logic              ud_s;

  int vectors     = 0;
  int miscompares = 0;

  logic [CW-1:0] exp_q[$];
  logic          exp_dir_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  cnt_sweep_ctrl #(
    .MAX    (MAX),
    .MIN    (MIN),
    .STEP_W (STEP_W)
  ) dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .cmd_mode   (cmd_mode),
    .hold       (hold),
    .abort      (abort),
    .cnt_in     (cnt),
    .cnt_en     (cnt_en),
    .cnt_ud     (cnt_ud),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left),
    .state      (state_dbg)
  );

  // Attached counter: direction sampled on the falling edge, step on rise.
  always @(negedge clk) ud_s <= cnt_ud;

  always @(posedge clk) begin
    if (load) begin
      cnt <= load_val;
    end else if (cnt_en) begin
      cnt <= ud_s ? CW'(MIN + ((int'(cnt) - MIN + RANGE - 1) % RANGE))
                  : CW'(MIN + ((int'(cnt) - MIN + 1) % RANGE));
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected counter value and direction after/for every step of a sweep.
  task automatic build_model(input int start, input logic dir, input int steps, input logic pp);
    int   c;
    logic d;
    exp_q.delete();
    exp_dir_q.delete();
    c = start;
    d = dir;
    for (int k = 0; k < steps; k++) begin
      if (pp && (MIN != MAX)) begin
        if (c == MAX) d = 1'b1;
        else if (c == MIN) d = 1'b0;
      end
      exp_dir_q.push_back(d);
      c = d ? MIN + ((c - MIN + RANGE - 1) % RANGE) : MIN + ((c - MIN + 1) % RANGE);
      exp_q.push_back(CW'(c));
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full sweep. hold is high for cycles [hold_at, hold_at+hold_len) and
  // abort in cycle abort_at (0 = never), counted from the first cycle after
  // the accepting edge. abort_idle drives abort during the accept cycle.
  task automatic run_sweep(input logic dir, input int steps, input logic mode, input int start,
                           input int hold_at, input int hold_len, input int abort_at,
                           input logic abort_idle);
    int            taken;
    int            phase;   // 0 stepping, 1 completion cycle, 2 back to idle
    logic          h;
    logic          a;
    logic [CW-1:0] exp_cnt;
    logic          fin_dir;
    load     = 1'b1;
    load_val = CW'(start);
    tick();
    load     = 1'b0;
    build_model(start, dir, steps, mode && PP_BUILD);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = STEP_W'(steps);
    cmd_mode  = mode;
    abort     = abort_idle;
    hold      = 1'b0;
    @(negedge clk);
    chk("accept_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    cmd_dir   = 1'($urandom);
    cmd_steps = STEP_W'($urandom);
    cmd_mode  = 1'($urandom);
    abort     = 1'b0;
    taken     = 0;
    phase     = (steps == 0) ? 1 : 0;
    for (int j = 1; (j <= steps + hold_len + 4) && (phase != 2); j++) begin
      h     = (j >= hold_at) && (j < hold_at + hold_len);
      a     = (j == abort_at);
      hold  = h;
      abort = a;
      @(negedge clk);
      exp_cnt = (taken == 0) ? CW'(start) : exp_q[(taken == 0) ? 0 : taken - 1];
      chk("cnt", cnt, exp_cnt);
      if (phase == 0) begin
        chk("run_en", cnt_en, !h && !a);
        chk("run_left", steps_left, steps - taken);
        chk("run_busy", busy, 1);
        chk("run_ready", cmd_ready, 0);
        chk("run_done", done, 0);
        chk("run_ud", cnt_ud, exp_dir_q[taken]);
        if (a) begin
          phase = 2;
        end else if (!h) begin
          taken++;
          if (taken == steps) phase = 1;
        end
      end else begin
        fin_dir = (taken == 0) ? dir : exp_dir_q[(taken == 0) ? 0 : taken - 1];
        chk("done_pulse", done, !a);
        chk("done_en", cnt_en, 0);
        chk("done_left", steps_left, 0);
        chk("done_busy", busy, 1);
        chk("done_ud", cnt_ud, fin_dir);
        phase = 2;
      end
      tick();
    end
    hold  = 1'b0;
    abort = 1'b0;
    fin_dir = (taken == 0) ? dir : exp_dir_q[(taken == 0) ? 0 : taken - 1];
    exp_cnt = (taken == 0) ? CW'(start) : exp_q[(taken == 0) ? 0 : taken - 1];
    @(negedge clk);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_en", cnt_en, 0);
    chk("idle_left", steps_left, 0);
    chk("idle_ud", cnt_ud, fin_dir);
    chk("final_cnt", cnt, exp_cnt);
    tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int st;
    int ha;
    int hl;
    int ab;
    sys_rst   = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_steps = '0;
    cmd_mode  = 1'b0;
    hold      = 1'b0;
    abort     = 1'b0;
    load      = 1'b1;
    load_val  = '0;
    #2;
    chk("rst_en", cnt_en, 0);
    chk("rst_ud", cnt_ud, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_left", steps_left, 0);
    repeat (2) @(posedge clk);
    #1;
    sys_rst = 1'b0;
    load    = 1'b0;
    tick();

    // Single up 5 from 3, single down 4 from 1 (wraps), ping-pong up 25 from 10.
    run_sweep(DIR_UP,   5,  MODE_SINGLE,   3,  0, 0, 0, 1'b0);
    run_sweep(DIR_DOWN, 4,  MODE_SINGLE,   1,  0, 0, 0, 1'b0);
    run_sweep(DIR_UP,   25, MODE_PINGPONG, 10, 0, 0, 0, 1'b0);
    // Ping-pong down starting on MIN must bounce up immediately.
    run_sweep(DIR_DOWN, 6,  MODE_PINGPONG, MIN, 0, 0, 0, 1'b0);
    // 6 steps with a 3-cycle hold mid-run.
    run_sweep(DIR_UP,   6,  MODE_SINGLE,   2,  3, 3, 0, 1'b0);
    // Abort after 2 of 10 steps.
    run_sweep(DIR_UP,   10, MODE_SINGLE,   0,  0, 0, 3, 1'b0);
    // Abort during a hold, and abort in the completion cycle.
    run_sweep(DIR_DOWN, 5,  MODE_PINGPONG, 1,  2, 3, 3, 1'b0);
    run_sweep(DIR_UP,   3,  MODE_SINGLE,   14, 0, 0, 4, 1'b0);
    // Zero-step command, with abort high in IDLE during the accept.
    run_sweep(DIR_DOWN, 0,  MODE_SINGLE,   4,  0, 0, 0, 1'b1);

    // Reset in the middle of an 8-step down sweep.
    load     = 1'b1;
    load_val = CW'(7);
    tick();
    load      = 1'b0;
    cmd_valid = 1'b1;
    cmd_dir   = DIR_DOWN;
    cmd_steps = STEP_W'(8);
    cmd_mode  = MODE_SINGLE;
    tick();
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_en", cnt_en, 1);
    chk("pre_rst_ud", cnt_ud, DIR_DOWN);
    sys_rst = 1'b1;
    #1;
    chk("mid_rst_en", cnt_en, 0);
    chk("mid_rst_ud", cnt_ud, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_left", steps_left, 0);
    chk("mid_rst_state", state_dbg, IDLE);
    tick();
    sys_rst = 1'b0;
    tick();
    run_sweep(DIR_UP, 7, MODE_SINGLE, 12, 0, 0, 0, 1'b0);

    // Randomized commands.
    for (int i = 0; i < 16; i++) begin
      st = $urandom_range(0, 40);
      ha = $urandom_range(1, st + 1);
      hl = $urandom_range(0, 4);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, st + hl + 1) : 0;
      run_sweep(1'($urandom_range(0, 1)), st, 1'($urandom_range(0, 1)),
                $urandom_range(MIN, MAX), ha, hl, ab, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
